// File: rtl/margin_calc.sv
// rtl/margin_calc.sv - per-row top-1 minus top-2 class-score margin with credit-controlled output FIFO
module margin_calc #(
  parameter int N_SAMPLES  = 10240,
  parameter int N_LANES    = 16,
  parameter int ROW_STRIDE = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  output logic         done,
  output logic         mem_en,
  output logic [31:0]  mem_addr,
  input  logic [255:0] mem_dout,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [15:0]  m_margin,
  output logic [15:0]  m_index,
  output logic         m_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]     state;
  logic [31:0]    rd_idx;
  logic [15:0]    wr_idx;
  logic           v0;
  logic           v1;
  logic [255:0]   row_q;
  logic [15:0]    top1;
  logic [15:0]    top2;
  logic [15:0]    lane;
  logic [15:0]    fifo_margin [FIFO_DEPTH];
  logic [15:0]    fifo_index  [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [31:0]    used;
  logic           fifo_wr;
  logic           fifo_rd;

  // Credits: stored entries plus reads still travelling through the BRAM and capture stages
  assign used     = 32'(count) + 32'(v0) + 32'(v1);
  assign mem_en   = (state == S_RUN) && (used < 32'(FIFO_DEPTH));
  assign mem_addr = rd_idx * 32'(ROW_STRIDE);
  assign ready    = (state == S_IDLE);
  assign done     = (state == S_DONE);

  assign fifo_wr  = v1;
  assign fifo_rd  = m_valid & m_ready;
  assign m_valid  = (count != '0);
  assign m_margin = m_valid ? fifo_margin[rd_ptr] : 16'd0;
  assign m_index  = m_valid ? fifo_index[rd_ptr] : 16'd0;
  assign m_last   = m_valid && (m_index == 16'(N_SAMPLES - 1));

  // Run control: IDLE -> RUN on start, RUN -> DRAIN after the last read, DRAIN -> DONE on the last handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      rd_idx <= 32'd0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_RUN;
        S_RUN: begin
          if (mem_en) begin
            rd_idx <= rd_idx + 32'd1;
            if (rd_idx == 32'(N_SAMPLES - 1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: if (fifo_rd && m_last) state <= S_DONE;
        S_DONE: begin
          state  <= S_IDLE;
          rd_idx <= 32'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read pipeline: v0 marks BRAM data valid this cycle, v1 marks the captured row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0    <= 1'b0;
      v1    <= 1'b0;
      row_q <= '0;
    end else begin
      v0 <= mem_en;
      v1 <= v0;
      if (v0) row_q <= mem_dout;
    end
  end

  // Top-2 over the lane multiset; a value equal to the max still displaces the runner-up
  always_comb begin
    top1 = 16'd0;
    top2 = 16'd0;
    lane = 16'd0;
    for (int k = 0; k < N_LANES; k++) begin
      lane = row_q[16*k +: 16];
      if (lane > top1) begin
        top2 = top1;
        top1 = lane;
      end else if (lane > top2) begin
        top2 = lane;
      end
    end
  end

  // FIFO storage; contents need no reset because m_valid gates the read side
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_margin[wr_ptr] <= top1 - top2;
      fifo_index[wr_ptr]  <= wr_idx;
    end
  end

  // FIFO pointers, occupancy and output index counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_idx <= 16'd0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        wr_idx <= wr_idx + 16'd1;
      end
      if (fifo_rd) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == S_DONE) wr_idx <= 16'd0;
    end
  end

endmodule

// File: tb/tb_margin_calc.sv
// tb/tb_margin_calc.sv - directed self-checking bench for margin_calc
module tb_margin_calc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         s_start, s_ready, s_done, s_mem_en, s_m_valid, s_m_ready, s_m_last;
  logic [31:0]  s_mem_addr;
  logic [255:0] s_mem_dout;
  logic [15:0]  s_m_margin, s_m_index;
  logic         b_start, b_ready, b_done, b_mem_en, b_m_valid, b_m_ready, b_m_last;
  logic [31:0]  b_mem_addr;
  logic [255:0] b_mem_dout;
  logic [15:0]  b_m_margin, b_m_index;

  int errors = 0;
  int checks = 0;
  logic [255:0] s_rows [4];
  int exp_margin [4];

  margin_calc #(.N_SAMPLES(4)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .ready(s_ready), .done(s_done),
    .mem_en(s_mem_en), .mem_addr(s_mem_addr), .mem_dout(s_mem_dout),
    .m_valid(s_m_valid), .m_ready(s_m_ready), .m_margin(s_m_margin),
    .m_index(s_m_index), .m_last(s_m_last)
  );

  margin_calc dut_b (
    .clk(clk), .rst(rst), .start(b_start), .ready(b_ready), .done(b_done),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_dout(b_mem_dout),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_margin(b_m_margin),
    .m_index(b_m_index), .m_last(b_m_last)
  );

  // Large run rows: lane0 = i, lane1 = i/2, so the margin is i - i/2
  function automatic logic [255:0] big_row(input logic [31:0] i);
    logic [255:0] r;
    r = '0;
    r[15:0]  = i[15:0];
    r[31:16] = i[16:1];
    return r;
  endfunction

  // Sample BRAM models with one cycle read latency
  always @(posedge clk) if (s_mem_en) s_mem_dout <= s_rows[s_mem_addr[6:5]];
  always @(posedge clk) if (b_mem_en) b_mem_dout <= big_row(b_mem_addr >> 5);

  task automatic test_reset();
    rst = 1'b1;
    s_start = 1'b0; s_m_ready = 1'b0;
    b_start = 1'b0; b_m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, s_done, s_mem_en, s_m_valid, s_m_last, s_mem_addr, s_m_margin, s_m_index} !== {1'b1, 4'b0, 32'd0, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_small: got rdy=%b done=%b en=%b val=%b last=%b addr=%0d marg=%0d idx=%0d expected 1,0,0,0,0,0,0,0",
               s_ready, s_done, s_mem_en, s_m_valid, s_m_last, s_mem_addr, s_m_margin, s_m_index);
    end
    checks++;
    if ({b_ready, b_done, b_mem_en, b_m_valid, b_m_last, b_mem_addr, b_m_margin, b_m_index} !== {1'b1, 4'b0, 32'd0, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_big: got rdy=%b done=%b en=%b val=%b last=%b addr=%0d marg=%0d idx=%0d expected 1,0,0,0,0,0,0,0",
               b_ready, b_done, b_mem_en, b_m_valid, b_m_last, b_mem_addr, b_m_margin, b_m_index);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, s_mem_en, s_m_valid} !== 3'b100) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy/en/val=%b expected 100", {s_ready, s_mem_en, s_m_valid});
    end
  endtask

  task automatic test_single_run();
    int first_en = -1, first_val = -1, done_c = -1, hs_c = -1;
    int nrec = 0, n_done = 0, n_en = 0;
    logic ready_after = 1'b0;
    s_m_ready = 1'b1;
    s_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) s_start = 1'b0;
      if (s_mem_en) begin
        n_en++;
        if (first_en < 0) first_en = c;
      end
      if (s_m_valid && first_val < 0) first_val = c;
      if (s_done) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c == done_c + 1) ready_after = s_ready;
      if (s_m_valid && s_m_ready && nrec < 4) begin
        checks++;
        if (s_m_index !== 16'(nrec)) begin
          errors++;
          $display("FAIL run_index: got %0d expected %0d", s_m_index, nrec);
        end
        checks++;
        if (s_m_margin !== 16'(exp_margin[nrec])) begin
          errors++;
          $display("FAIL run_margin[%0d]: got %0d expected %0d", nrec, s_m_margin, exp_margin[nrec]);
        end
        checks++;
        if (s_m_last !== (nrec == 3)) begin
          errors++;
          $display("FAIL run_last[%0d]: got %b expected %b", nrec, s_m_last, nrec == 3);
        end
        if (nrec == 3) hs_c = c;
        nrec++;
      end
    end
    checks++;
    if (first_en != 1) begin
      errors++;
      $display("FAIL first_mem_en_latency: got %0d expected 1", first_en);
    end
    checks++;
    if (first_val - first_en != 3) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d expected 3", first_val - first_en);
    end
    checks++;
    if (nrec != 4 || n_en != 4) begin
      errors++;
      $display("FAIL run_counts: got records=%0d reads=%0d expected 4 4", nrec, n_en);
    end
    checks++;
    if (n_done != 1 || hs_c < 0 || done_c != hs_c + 1) begin
      errors++;
      $display("FAIL done_timing: got pulses=%0d done_cycle=%0d last_hs=%0d expected 1 pulse one cycle after last", n_done, done_c, hs_c);
    end
    checks++;
    if (ready_after !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_done: got %b expected 1", ready_after);
    end
  endtask

  task automatic test_backpressure();
    int n_en = 0, unstable = 0, nrec = 0, bad = 0, n_done = 0;
    s_m_ready = 1'b0;
    s_start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) s_start = 1'b0;
      if (s_mem_en) n_en++;
      if (s_m_valid && (s_m_index !== 16'd0 || s_m_margin !== 16'd3)) unstable++;
    end
    checks++;
    if (n_en != 4) begin
      errors++;
      $display("FAIL stall_reads: got %0d expected 4", n_en);
    end
    checks++;
    if ({s_m_valid, s_m_index, s_m_margin} !== {1'b1, 16'd0, 16'd3} || unstable != 0) begin
      errors++;
      $display("FAIL stall_hold: got valid=%b idx=%0d marg=%0d unstable=%0d expected 1 0 3 0", s_m_valid, s_m_index, s_m_margin, unstable);
    end
    s_m_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (s_m_valid && s_m_ready) begin
        if (nrec > 3 || s_m_index !== 16'(nrec) || s_m_margin !== 16'(exp_margin[nrec & 3])) bad++;
        nrec++;
      end
      if (s_done) n_done++;
      @(negedge clk);
    end
    checks++;
    if (nrec != 4 || bad != 0 || n_done != 1) begin
      errors++;
      $display("FAIL stall_release: got records=%0d bad=%0d done=%0d expected 4 0 1", nrec, bad, n_done);
    end
  endtask

  task automatic test_start_ignored();
    int nrec = 0, bad = 0, n_done = 0, n_en = 0;
    s_start = 1'b1;
    s_m_ready = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      s_start = (c == 2 || c == 6);
      s_m_ready = (c % 3 != 0);
      if (s_mem_en) n_en++;
      if (s_done) n_done++;
      if (s_m_valid && s_m_ready) begin
        if (nrec > 3 || s_m_index !== 16'(nrec) || s_m_margin !== 16'(exp_margin[nrec & 3])) bad++;
        nrec++;
      end
    end
    s_start = 1'b0;
    checks++;
    if (nrec != 4 || bad != 0 || n_done != 1 || n_en != 4) begin
      errors++;
      $display("FAIL start_ignored: got records=%0d bad=%0d done=%0d reads=%0d expected 4 0 1 4", nrec, bad, n_done, n_en);
    end
  endtask

  task automatic test_reset_midrun();
    int found = 0, bad = 0, nrec = 0, bad_idx = 0, bad_marg = 0, bad_last = 0, n_done = 0;
    b_m_ready = 1'b1;
    b_start = 1'b1;
    for (int c = 1; c <= 400 && found == 0; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_m_valid && b_m_index == 16'd100) found = 1;
    end
    checks++;
    if (found != 1) begin
      errors++;
      $display("FAIL midrun_reach_100: got %0d expected 1", found);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({b_ready, b_done, b_mem_en, b_m_valid, b_m_last, b_mem_addr, b_m_margin, b_m_index} !== {1'b1, 4'b0, 32'd0, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL midrun_reset_values: got rdy=%b done=%b en=%b val=%b last=%b addr=%0d marg=%0d idx=%0d expected 1,0,0,0,0,0,0,0",
               b_ready, b_done, b_mem_en, b_m_valid, b_m_last, b_mem_addr, b_m_margin, b_m_index);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b_done || b_m_valid || !b_ready || b_mem_en) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrun_quiet_after_reset: got %0d bad cycles expected 0", bad);
    end
    b_start = 1'b1;
    for (int c = 1; c <= 12000 && n_done == 0; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_done) n_done++;
      if (b_m_valid && b_m_ready) begin
        if (b_m_index !== 16'(nrec)) bad_idx++;
        if (b_m_margin !== 16'(nrec - nrec / 2)) bad_marg++;
        if (b_m_last !== (nrec == 10239)) bad_last++;
        nrec++;
      end
    end
    checks++;
    if (nrec != 10240 || n_done != 1) begin
      errors++;
      $display("FAIL full_run_count: got records=%0d done=%0d expected 10240 1", nrec, n_done);
    end
    checks++;
    if (bad_idx != 0 || bad_marg != 0 || bad_last != 0) begin
      errors++;
      $display("FAIL full_run_data: got bad idx=%0d margin=%0d last=%0d expected 0 0 0", bad_idx, bad_marg, bad_last);
    end
  endtask

  initial begin
    s_rows[0] = '0; s_rows[0][15:0] = 16'd140; s_rows[0][31:16] = 16'd197; s_rows[0][47:32] = 16'd200;
    s_rows[1] = '0; s_rows[1][15:0] = 16'd14;  s_rows[1][31:16] = 16'd200; s_rows[1][47:32] = 16'd200;
    s_rows[2] = '0; s_rows[2][15:0] = 16'd250; s_rows[2][31:16] = 16'd186; s_rows[2][63:48] = 16'd1;
    s_rows[3] = '0;
    exp_margin[0] = 3; exp_margin[1] = 0; exp_margin[2] = 64; exp_margin[3] = 0;
    test_reset();
    test_single_run();
    test_backpressure();
    test_start_ignored();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/margin_calc.md
MARGIN_CALC -- requirements
Module: margin_calc

Interface
REQ-001 The module SHALL have parameter N_SAMPLES, default 10240, giving the number of sample rows processed per run.
REQ-002 The module SHALL have parameter N_LANES, default 16, giving the number of 16-bit unsigned class scores per 256-bit row; lane k is row bits [16k+15:16k].
REQ-003 The module SHALL have parameter ROW_STRIDE, default 32, giving the byte-address increment between rows.
REQ-004 The module SHALL have parameter FIFO_DEPTH, default 4, giving the output buffer depth in entries.
REQ-005 clk  in  1  the single clock; all logic is on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 start  in  1  one-cycle request to begin a run.
REQ-008 ready  out  1  high when idle and able to accept start.
REQ-009 done  out  1  one-cycle pulse when a run completes.
REQ-010 mem_en  out  1  row read enable to the sample BRAM.
REQ-011 mem_addr  out  32  byte address of the row read (index*ROW_STRIDE).
REQ-012 mem_dout  in  256  row data, valid exactly 1 cycle after the mem_en cycle.
REQ-013 m_valid  out  1  output record valid.
REQ-014 m_ready  in  1  downstream (top-10 selector) accepts the record.
REQ-015 m_margin  out  16  top-1 score minus top-2 score for the row.
REQ-016 m_index  out  16  sample index of the row (0..N_SAMPLES-1).
REQ-017 m_last  out  1  high with the record for index N_SAMPLES-1.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE; ready SHALL be high only in IDLE.
REQ-019 IDLE->RUN SHALL occur on start=1; start outside IDLE SHALL be ignored.
REQ-020 In RUN, a read SHALL be issued (mem_en=1, next index) only when FIFO occupancy plus reads in flight is less than FIFO_DEPTH; otherwise mem_en SHALL be 0.
REQ-021 After the read for index N_SAMPLES-1 is issued, the FSM SHALL go RUN->DRAIN.
REQ-022 DRAIN->DONE SHALL occur on the cycle the m_last record handshakes (m_valid & m_ready); DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-023 Pipeline: read issue at cycle t, mem_dout captured at t+1, top-2 registered at t+2, FIFO write at t+2; on an empty FIFO, m_valid SHALL be high from t+3.
REQ-024 Top-2 SHALL be the largest and second-largest of the N_LANES lane values taken as a multiset, unsigned; equal maxima SHALL give margin 0.
REQ-025 m_margin SHALL be computed as the 16-bit unsigned difference of top-1 and top-2, which never underflows.
REQ-026 A record SHALL leave the FIFO only on m_valid & m_ready.
REQ-027 m_valid SHALL NOT depend combinationally on m_ready.
REQ-028 Output fields SHALL stay stable while m_valid=1 and m_ready=0.
REQ-029 Records SHALL be emitted in strictly increasing m_index with no loss or duplication under any m_ready pattern.
REQ-030 A simultaneous FIFO write and read on a full FIFO SHALL be legal; the credit rule (REQ-020) SHALL prevent any write to a full FIFO without a read.
REQ-031 The index counter SHALL NOT wrap within a run; a new run SHALL restart at index 0 and address 0.

Reset
REQ-032 While rst=1, the module SHALL force: state IDLE, ready=1, done=0, mem_en=0, mem_addr=0, m_valid=0, m_margin=0, m_index=0, m_last=0, FIFO empty, credit and in-flight counters 0.
REQ-033 Reset asserted mid-run SHALL abort the run immediately; in-flight read data SHALL be discarded, and no done pulse SHALL occur.

Verification
REQ-034 Row lanes {140,197,200,0,...0} at index 0 -> m_margin=3, m_index=0.
REQ-035 Rows {14,200,200,0}, {250,186,0,1} and all-zero -> margins 0, 64 and 0 respectively.
REQ-036 With N_SAMPLES=4 and m_ready held at 1: first mem_en 1 cycle after start, first m_valid 3 cycles after the first mem_en, 4 records with m_last on index 3, done 1 cycle after that handshake, then ready=1.
REQ-037 m_ready=0 for 20 cycles after start -> exactly 4 mem_en cycles, m_valid held with record index 0; after release, the full index sequence arrives with no gaps.
REQ-038 rst pulsed at index ~100 of a 10240-sample run -> all outputs at reset values; a new start gives index 0 and a correct full run.
REQ-039 start pulsed during RUN -> ignored, with a single done pulse and N_SAMPLES records total.
